// File: rtl/seq_divider.sv
// Multi-cycle signed restoring divider for the ALU DIV path.
// Returns {remainder, quotient}; divide-by-zero flagged via dbz.
module seq_divider #(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               clear,
   input  logic               start,
   input  logic [WIDTH-1:0]   dividend,
   input  logic [WIDTH-1:0]   divisor,
   output logic               busy,
   output logic               done,
   output logic               dbz,
   output logic [2*WIDTH-1:0] result
);

   localparam int CW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ITER,
      S_FIX,
      S_DONE
   } state_t;

   state_t state, state_nx;

   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] q;
   logic [WIDTH-1:0] m;
   logic [CW-1:0]    cnt;
   logic             sign_q;
   logic             sign_r;

   logic             accept;
   logic             div_zero;
   logic             last_iter;
   logic [WIDTH:0]   a_sh;
   logic [WIDTH:0]   a_diff;
   logic [WIDTH-1:0] abs_dvd;
   logic [WIDTH-1:0] abs_dvs;
   logic [WIDTH-1:0] q_fix;
   logic [WIDTH-1:0] r_fix;

   assign accept    = start && (state == S_IDLE || state == S_DONE);
   assign div_zero  = (divisor == '0);
   assign last_iter = (cnt == CW'(WIDTH - 1));

   // Magnitudes wrap for the most negative value, which is then read unsigned.
   assign abs_dvd = dividend[WIDTH-1] ? -dividend : dividend;
   assign abs_dvs = divisor[WIDTH-1] ? -divisor : divisor;

   // Shifted partial remainder and trial subtraction; a_diff[WIDTH] set = negative.
   assign a_sh   = {a, q[WIDTH-1]};
   assign a_diff = a_sh - {1'b0, m};

   assign q_fix = sign_q ? -q : q;
   assign r_fix = sign_r ? -a : a;

   // State register.
   always_ff @(posedge clk or posedge clear) begin
      if (clear) state <= S_IDLE;
      else       state <= state_nx;
   end

   // Next-state and status outputs.
   always_comb begin
      state_nx = state;
      busy     = 1'b0;
      done     = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (start) state_nx = div_zero ? S_DONE : S_ITER;
         end
         S_ITER: begin
            busy = 1'b1;
            if (last_iter) state_nx = S_FIX;
         end
         S_FIX: begin
            busy     = 1'b1;
            state_nx = S_DONE;
         end
         S_DONE: begin
            done = 1'b1;
            if (start) state_nx = div_zero ? S_DONE : S_ITER;
            else       state_nx = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   // Operand capture, iteration datapath and result write.
   always_ff @(posedge clk or posedge clear) begin
      if (clear) begin
         a      <= '0;
         q      <= '0;
         m      <= '0;
         cnt    <= '0;
         sign_q <= 1'b0;
         sign_r <= 1'b0;
         dbz    <= 1'b0;
         result <= '0;
      end else if (accept) begin
         if (div_zero) begin
            result <= {dividend, {WIDTH{1'b1}}};
            dbz    <= 1'b1;
         end else begin
            a      <= '0;
            q      <= abs_dvd;
            m      <= abs_dvs;
            sign_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            sign_r <= dividend[WIDTH-1];
            cnt    <= '0;
            dbz    <= 1'b0;
         end
      end else if (state == S_ITER) begin
         if (!a_diff[WIDTH]) a <= a_diff[WIDTH-1:0];
         else                a <= a_sh[WIDTH-1:0];
         q   <= {q[WIDTH-2:0], ~a_diff[WIDTH]};
         cnt <= cnt + CW'(1);
      end else if (state == S_FIX) begin
         result <= {r_fix, q_fix};
      end
   end

endmodule

// File: tb/tb_seq_divider.sv
// Directed and scoreboard bench for seq_divider.
// Table vectors plus hand sequences for restart, reset and back-to-back.
module tb_seq_divider;

   logic        clk = 1'b0;
   logic        clear;
   logic        start;
   logic [31:0] dividend;
   logic [31:0] divisor;
   logic        busy;
   logic        done;
   logic        dbz;
   logic [63:0] result;

   int n_pass = 0;
   int n_total = 0;
   int overlap = 0;

   seq_divider #(.WIDTH(32)) dut (
      .clk      (clk),
      .clear    (clear),
      .start    (start),
      .dividend (dividend),
      .divisor  (divisor),
      .busy     (busy),
      .done     (done),
      .dbz      (dbz),
      .result   (result)
   );

   always #5 clk = ~clk;

   // Watch for busy and done high together.
   always @(negedge clk) if (busy && done) overlap++;

   typedef struct {
      logic [31:0] dvd;
      logic [31:0] dvs;
      logic [63:0] res;
      logic        dz;
   } vec_t;

   task automatic check(input string nm, input logic [63:0] got,
                        input logic [63:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", nm, got, exp);
   endtask

   // Raise start at the negedge, accept on the next posedge, return #1 after.
   task automatic accept(input logic [31:0] x, input logic [31:0] y,
                         input bit hold);
      @(negedge clk);
      start    = 1'b1;
      dividend = x;
      divisor  = y;
      @(posedge clk);
      #1;
      if (!hold) start = 1'b0;
   endtask

   // Count edges until done; called #1 after the edge that starts the count.
   task automatic wait_done(input string nm, input int lat,
                            input logic [63:0] res, input logic dz);
      int n;
      n = 0;
      while (!done && n <= 40) begin
         @(posedge clk);
         #1;
         n++;
      end
      check({nm, "_lat"}, 64'(n), 64'(lat));
      check({nm, "_res"}, result, res);
      check({nm, "_dbz"}, 64'(dbz), 64'(dz));
   endtask

   vec_t vt[$];

   initial begin
      clear    = 1'b1;
      start    = 1'b0;
      dividend = '0;
      divisor  = '0;

      vt.push_back('{32'd20, 32'd5, 64'h00000000_00000004, 1'b0});
      vt.push_back('{-32'sd7, 32'd2, 64'hFFFFFFFF_FFFFFFFD, 1'b0});
      vt.push_back('{32'd7, -32'sd2, 64'h00000001_FFFFFFFD, 1'b0});
      vt.push_back('{-32'sd7, -32'sd2, 64'hFFFFFFFF_00000003, 1'b0});
      vt.push_back('{32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 1'b0});
      vt.push_back('{32'hFFFFFFFF, 32'd1, 64'h00000000_FFFFFFFF, 1'b0});
      vt.push_back('{32'd9, 32'd0, 64'h00000009_FFFFFFFF, 1'b1});
      vt.push_back('{32'd100, 32'd7, 64'h00000002_0000000E, 1'b0});
      vt.push_back('{32'd0, 32'd5, 64'h00000000_00000000, 1'b0});
      vt.push_back('{32'h80000000, 32'd1, 64'h00000000_80000000, 1'b0});
      vt.push_back('{32'd1, 32'h80000000, 64'h00000001_00000000, 1'b0});
      vt.push_back('{32'h80000000, 32'h80000000, 64'h00000000_00000001, 1'b0});
      vt.push_back('{32'hFFFFFFFF, 32'h80000000, 64'hFFFFFFFF_00000000, 1'b0});
      vt.push_back('{32'h7FFFFFFF, 32'h80000000, 64'h7FFFFFFF_00000000, 1'b0});
      vt.push_back('{-32'sd5, 32'd0, 64'hFFFFFFFB_FFFFFFFF, 1'b1});
      vt.push_back('{32'd7, 32'd7, 64'h00000000_00000001, 1'b0});

      repeat (2) @(posedge clk);
      #1;
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_dbz", 64'(dbz), 64'd0);
      check("rst_result", result, 64'd0);
      @(negedge clk);
      clear = 1'b0;

      foreach (vt[i]) begin
         accept(vt[i].dvd, vt[i].dvs, 1'b0);
         wait_done($sformatf("vec%0d", i), vt[i].dz ? 0 : 33,
                   vt[i].res, vt[i].dz);
      end

      // Restart attempt mid-operation and operand churn are ignored.
      accept(32'd100, 32'd7, 1'b0);
      for (int i = 1; i <= 10; i++) begin
         @(negedge clk);
         dividend = $urandom;
         divisor  = $urandom;
         if (i == 10) begin
            start    = 1'b1;
            dividend = 32'd1;
            divisor  = 32'd1;
         end
         @(posedge clk);
         #1;
         start = 1'b0;
      end
      check("restart_busy", 64'(busy), 64'd1);
      wait_done("restart", 23, 64'h00000002_0000000E, 1'b0);

      // Reset mid-iteration discards the division immediately.
      accept(32'd100, 32'd7, 1'b0);
      repeat (15) @(posedge clk);
      @(negedge clk);
      clear = 1'b1;
      #1;
      check("clr_busy", 64'(busy), 64'd0);
      check("clr_done", 64'(done), 64'd0);
      check("clr_result", result, 64'd0);
      @(negedge clk);
      clear = 1'b0;
      accept(32'd50, 32'd8, 1'b0);
      wait_done("after_clr", 33, 64'h00000002_00000006, 1'b0);

      // Back-to-back: start held through DONE starts the next op at once.
      accept(32'd20, 32'd5, 1'b1);
      dividend = -32'sd7;
      divisor  = 32'd2;
      wait_done("b2b_a", 33, 64'h00000000_00000004, 1'b0);
      @(posedge clk);
      #1;
      start = 1'b0;
      check("b2b_busy", 64'(busy), 64'd1);
      wait_done("b2b_b", 33, 64'hFFFFFFFF_FFFFFFFD, 1'b0);

      // Scoreboard against the language operators.
      for (int k = 0; k < 24; k++) begin
         logic signed [31:0] x, y, eq, er;
         logic [63:0] er64;
         x = $signed($urandom);
         y = $signed($urandom);
         case (k % 6)
            0: y = 32'sd0;
            1: y = 32'sd1;
            2: y = -32'sd1;
            3: x = 32'sh80000000;
            4: y = $signed($urandom_range(1, 100));
            default: ;
         endcase
         if (k == 3) y = -32'sd1;
         if (y == 0) begin
            er64 = {x, 32'hFFFFFFFF};
         end else if (x == 32'sh80000000 && y == -32'sd1) begin
            er64 = {32'd0, 32'h80000000};
         end else begin
            eq   = x / y;
            er   = x % y;
            er64 = {er, eq};
         end
         accept(x, y, 1'b0);
         wait_done($sformatf("rnd%0d", k), (y == 0) ? 0 : 33,
                   er64, (y == 0));
      end

      check("busy_done_overlap", 64'(overlap), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
